// File: rtl/pixel_match_scan.sv
// pixel_match_scan
//   Scans one frame of NPIX pixels from a synchronous pixel memory and emits
//   one `add` pulse per pixel whose value lies inside [thr_lo, thr_hi]
//   (inclusive, unsigned, thresholds latched at start). The pulses feed an
//   external counter stage. `reset_add` clears that counter before the scan,
//   and `done` marks the cycle in which the count is final.
//
// Ports
//   clk, reset_n         clock, async active-low reset
//   start, abort         scan request (IDLE only) / synchronous cancel
//   thr_lo, thr_hi       inclusive match bounds
//   mem_addr, mem_rd     pixel read address and strobe (data returns 1 cycle later)
//   pix_data             pixel read data
//   add, reset_add       counter-stage increment pulse / clear pulse
//   busy, done           scan in progress / count-final pulse
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// CLEAR | one cycle, reset_add high, mem_addr = 0
// READ  | mem_rd high, mem_addr steps 0..NPIX-1
// DRAIN | two cycles, flushes the memory and match pipeline
// DONE  | one cycle, done high
module pixel_match_scan #(
    parameter int NPIX = 16384,
    parameter int AW   = 14,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] thr_lo,
    input  logic [DW-1:0] thr_hi,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] pix_data,
    output logic          add,
    output logic          reset_add,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] last_addr = AW'(NPIX - 1);

    state_t        state;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] hi_q;
    logic          rd_q;       // mem_rd delayed: pix_data is valid this cycle
    logic          drain_cnt;
    logic          pix_match;

    // An inverted window (lo > hi) can never satisfy both bounds.
    assign pix_match = (pix_data >= lo_q) && (pix_data <= hi_q);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            rd_q      <= 1'b0;
            drain_cnt <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            add       <= 1'b0;
            reset_add <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_q      <= mem_rd;
            add       <= rd_q && pix_match;
            reset_add <= 1'b0;
            done      <= 1'b0;
            if (abort && state != IDLE) begin
                // mem_addr intentionally holds; in-flight reads are discarded.
                state  <= IDLE;
                mem_rd <= 1'b0;
                rd_q   <= 1'b0;
                add    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            lo_q      <= thr_lo;
                            hi_q      <= thr_hi;
                            mem_addr  <= '0;
                            reset_add <= 1'b1;
                            state     <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        mem_rd <= 1'b1;
                        state  <= READ;
                    end
                    READ: begin
                        if (mem_addr == last_addr) begin
                            mem_rd    <= 1'b0;
                            drain_cnt <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_match_scan.sv
module tb_pixel_match_scan;

    localparam int NPIX = 16;
    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int NS   = NPIX + 6;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [DW-1:0] thr_lo;
    logic [DW-1:0] thr_hi;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] pix_data;
    logic          add;
    logic          reset_add;
    logic          busy;
    logic          done;

    logic [DW-1:0] pix_mem [0:NPIX-1];
    logic [14:0]   sum = '0;
    int            n_checks = 0;
    int            n_fail   = 0;

    pixel_match_scan #(.NPIX(NPIX), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .thr_lo    (thr_lo),
        .thr_hi    (thr_hi),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .pix_data  (pix_data),
        .add       (add),
        .reset_add (reset_add),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pixel memory: data for the address of cycle t appears in t+1.
    always @(posedge clk) pix_data <= pix_mem[mem_addr];

    // Downstream counter stage.
    always @(posedge clk) begin
        if (reset_add)
            sum <= '0;
        else if (add)
            sum <= sum + 1'b1;
    end

    function automatic bit in_rng(input logic [DW-1:0] p, input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        return (int'(p) >= int'(lo)) && (int'(p) <= int'(hi));
    endfunction

    // Runs one frame and checks every cycle from CLEAR (k=0) to two cycles
    // past DONE against the expected timeline. With noise set, thresholds and
    // start are scrambled during the scan; they must not matter.
    task automatic test_scan(input string name, input logic [DW-1:0] lo, input logic [DW-1:0] hi, input bit noise);
        int nmatch;
        logic [4:0] ob, ex;
        logic [AW-1:0] exa;
        bit exp_add;
        nmatch = 0;
        for (int i = 0; i < NPIX; i++) if (in_rng(pix_mem[i], lo, hi)) nmatch++;
        @(negedge clk);
        thr_lo = lo; thr_hi = hi; start = 1'b1;
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            exp_add = 1'b0;
            if (k >= 3 && k <= NPIX + 2) exp_add = in_rng(pix_mem[k-3], lo, hi);
            ex  = {k <= NPIX + 3, k == NPIX + 3, k == 0, (k >= 1 && k <= NPIX), exp_add};
            ob  = {busy, done, reset_add, mem_rd, add};
            exa = (k == 0) ? '0 : (k <= NPIX) ? AW'(k - 1) : AW'(NPIX - 1);
            n_checks++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL %s k=%0d {busy,done,reset_add,mem_rd,add} got %b exp %b", name, k, ob, ex);
            end
            n_checks++;
            if (mem_addr !== exa) begin
                n_fail++;
                $display("FAIL %s k=%0d mem_addr got %0d exp %0d", name, k, mem_addr, exa);
            end
            if (k == 1) begin
                n_checks++;
                if (sum !== 15'd0) begin
                    n_fail++;
                    $display("FAIL %s sum_cleared got %0d exp 0", name, sum);
                end
            end
            if (k == NPIX + 3) begin
                n_checks++;
                if (sum !== 15'(nmatch)) begin
                    n_fail++;
                    $display("FAIL %s sum_at_done got %0d exp %0d", name, sum, nmatch);
                end
            end
            if (noise && k < NPIX + 3) begin
                thr_lo = DW'($urandom);
                thr_hi = DW'($urandom);
                start  = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; thr_lo = '0; thr_hi = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, reset_add, mem_rd, add} !== 5'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got %b/%0d exp 00000/0", {busy, done, reset_add, mem_rd, add}, mem_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release busy got %b exp 0", busy);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'(i);
        test_scan("ramp", 8'd4, 8'd7, 1'b0);
        n_checks++;
        if (sum !== 15'd4) begin
            n_fail++;
            $display("FAIL ramp_sum got %0d exp 4", sum);
        end
    endtask

    task automatic test_full_range();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'hFF;
        test_scan("full", 8'h00, 8'hFF, 1'b1);
        n_checks++;
        if (sum !== 15'd16) begin
            n_fail++;
            $display("FAIL full_sum got %0d exp 16", sum);
        end
    endtask

    task automatic test_inverted();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'($urandom_range(0, 15));
        test_scan("inverted", 8'd9, 8'd3, 1'b1);
        n_checks++;
        if (sum !== 15'd0) begin
            n_fail++;
            $display("FAIL inverted_sum got %0d exp 0", sum);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'($urandom);
        test_scan("b2b_first", 8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'($urandom_range(1, 255));
        pix_mem[2] = 8'd0;
        pix_mem[9] = 8'd0;
        n_checks++;
        if (sum !== 15'd16) begin
            n_fail++;
            $display("FAIL b2b_prior_sum got %0d exp 16", sum);
        end
        test_scan("b2b_second", 8'd0, 8'd0, 1'b1);
        n_checks++;
        if (sum !== 15'd2) begin
            n_fail++;
            $display("FAIL b2b_sum got %0d exp 2", sum);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a, b;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'($urandom);
            a = DW'($urandom);
            b = DW'($urandom);
            if (f < 3 && a > b) test_scan("random", b, a, 1'b1);
            else test_scan("random", a, b, 1'b1);
        end
    endtask

    task automatic test_abort();
        logic [AW-1:0] held;
        // abort in IDLE does nothing
        held = mem_addr;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || mem_addr !== held) begin
            n_fail++;
            $display("FAIL abort_idle busy/addr got %b/%0d exp 0/%0d", busy, mem_addr, held);
        end
        for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'($urandom_range(0, 20));
        thr_lo = 8'd5; thr_hi = 8'd15; start = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (mem_addr !== AW'(5) || mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pos addr/rd got %0d/%b exp 5/1", mem_addr, mem_rd);
        end
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_checks++;
        if ({busy, done, mem_rd, add} !== 4'b0 || mem_addr !== AW'(5)) begin
            n_fail++;
            $display("FAIL abort_exit {busy,done,rd,add}/addr got %b/%0d exp 0000/5", {busy, done, mem_rd, add}, mem_addr);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || add !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet k=%0d done/busy/add got %b%b%b exp 000", k, done, busy, add);
            end
        end
        test_scan("after_abort", 8'd5, 8'd15, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NPIX; i++) pix_mem[i] = DW'($urandom);
        @(negedge clk);
        thr_lo = 8'd0; thr_hi = 8'd255; start = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0; start = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, reset_add, mem_rd, add} !== 5'b0 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async got %b/%0d exp 00000/0", {busy, done, reset_add, mem_rd, add}, mem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || reset_add !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d busy/reset_add got %b%b exp 00", k, busy, reset_add);
            end
        end
        reset_n = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle busy/done got %b%b exp 00", busy, done);
        end
        test_scan("after_reset", 8'd40, 8'd200, 1'b1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_full_range();
        test_inverted();
        test_back_to_back();
        test_random();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
